// File: rtl/lb_pkg.sv
// Shared types and constants for the 3-row line buffer controller.
package lb_pkg;

  localparam int unsigned LB_MAX_W = 64;
  localparam int unsigned LB_SEL_W = 2;

  typedef enum logic [1:0] {
    LB_IDLE   = 2'd0,
    LB_FILL   = 2'd1,
    LB_STREAM = 2'd2,
    LB_FLUSH  = 2'd3
  } lb_state_t;

  // Row-memory roles: top holds row r-2, mid row r-1, bot row r.
  typedef struct packed {
    logic [LB_SEL_W-1:0] top;
    logic [LB_SEL_W-1:0] mid;
    logic [LB_SEL_W-1:0] bot;
  } lb_sels_t;

  localparam lb_sels_t LB_SELS_RST = '{top: 2'd1, mid: 2'd2, bot: 2'd0};

  function automatic lb_sels_t lb_rotate(input lb_sels_t s);
    lb_sels_t r;
    r.top = s.mid;
    r.mid = s.bot;
    r.bot = s.top;
    return r;
  endfunction

  function automatic logic [2:0] lb_onehot(input logic [LB_SEL_W-1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/lb_row_rotator.sv
// Holds the top/mid/bot row-memory selects; reloads on frame start and
// rotates one step at every row end.
module lb_row_rotator
  import lb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_init,
  input  logic     i_rotate,
  output lb_sels_t o_sels,
  output lb_sels_t o_sels_nxt_c
);

  lb_sels_t r_sels;

  always_comb begin : p_next
    o_sels_nxt_c = r_sels;
    if (i_init) begin
      o_sels_nxt_c = LB_SELS_RST;
    end else if (i_rotate) begin
      o_sels_nxt_c = lb_rotate(r_sels);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_reg
    if (reset) begin
      r_sels <= LB_SELS_RST;
    end else begin
      r_sels <= o_sels_nxt_c;
    end
  end

  assign o_sels = r_sels;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Raster-stream sequencer for a 3-row line buffer: write steering, row rotation
// and 3x3 window flagging. Optional stall counter enabled by LB_CTRL_PERF_EN.
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int unsigned int_bits = 20,
  parameter int unsigned MAX_W    = LB_MAX_W,
  parameter int unsigned CW       = $clog2(MAX_W),
  parameter int unsigned RW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW:0]   img_w,
  input  logic [RW-1:0] img_h,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [2:0]    wr_en,
  output logic [CW-1:0] addr,
  output logic [1:0]    top_sel,
  output logic [1:0]    mid_sel,
  output logic [1:0]    bot_sel,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          done,
`ifdef LB_CTRL_PERF_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          err
);

  // Pixel width only matters to the datapath; reject a meaningless setting early.
  generate
    if (int_bits == 0) begin : g_bad_int_bits
      $error("line_buffer_ctrl: int_bits must be non-zero");
    end
  endgenerate

  lb_state_t     r_state;
  lb_state_t     w_state_nxt;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW:0]   r_img_w;
  logic [RW-1:0] r_img_h;

  logic          r_win_valid;
  logic [CW-1:0] r_win_col;
  lb_sels_t      r_sels_out;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_dims_ok;
  logic          w_start_ok;
  logic          w_start_bad;
  logic          w_pix_ready;
  logic          w_flush_done;
  logic          w_accept;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_row_end;
  logic          w_win_sched;
  logic          w_win_hold;
  lb_sels_t      w_sels;
  lb_sels_t      w_sels_nxt;

  assign w_dims_ok  = (img_w >= (CW+1)'(3)) && (img_w <= (CW+1)'(MAX_W)) &&
                      (img_h >= RW'(3));
  assign w_last_col = ((CW+1)'(r_col) == (r_img_w - (CW+1)'(1)));
  assign w_last_row = (r_row == (r_img_h - RW'(1)));
  assign w_win_hold = r_win_valid & ~win_ready;
  assign w_accept   = pix_valid & w_pix_ready;
  assign w_row_end  = w_accept & w_last_col;
  assign w_win_sched = w_accept && (r_state == LB_STREAM) && (r_col >= CW'(2));

  always_ff @(posedge clk or posedge reset) begin : p_state_reg
    if (reset) begin
      r_state <= LB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_state_nxt
    w_state_nxt = r_state;
    case (r_state)
      LB_IDLE:   if (w_start_ok) w_state_nxt = LB_FILL;
      LB_FILL:   if (w_row_end && (r_row == RW'(1))) w_state_nxt = LB_STREAM;
      LB_STREAM: if (w_row_end && w_last_row) w_state_nxt = LB_FLUSH;
      LB_FLUSH:  if (w_flush_done) w_state_nxt = LB_IDLE;
      default:   w_state_nxt = LB_IDLE;
    endcase
  end

  // Flush may finish in the same cycle the last window is consumed.
  always_comb begin : p_state_out
    w_pix_ready  = 1'b0;
    w_flush_done = 1'b0;
    w_start_ok   = 1'b0;
    w_start_bad  = 1'b0;
    case (r_state)
      LB_IDLE: begin
        w_start_ok  = start & w_dims_ok;
        w_start_bad = start & ~w_dims_ok;
      end
      LB_FILL, LB_STREAM: w_pix_ready = ~w_win_hold;
      LB_FLUSH:           w_flush_done = ~r_win_valid | win_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : p_counters
    if (reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_img_w <= '0;
      r_img_h <= '0;
    end else if (w_start_ok) begin
      r_col   <= '0;
      r_row   <= '0;
      r_img_w <= img_w;
      r_img_h <= img_h;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  lb_row_rotator u_rotator (
    .clk          (clk),
    .reset        (reset),
    .i_init       (w_start_ok),
    .i_rotate     (w_row_end),
    .o_sels       (w_sels),
    .o_sels_nxt_c (w_sels_nxt)
  );

  // Window register keeps the pre-rotation sels of the window it flags.
  always_ff @(posedge clk or posedge reset) begin : p_window
    if (reset) begin
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
      r_sels_out  <= LB_SELS_RST;
    end else begin
      if (w_win_sched) begin
        r_win_valid <= 1'b1;
        r_win_col   <= r_col;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
      if (!w_win_hold) begin
        r_sels_out <= w_win_sched ? w_sels : w_sels_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_status
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_busy <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      r_done <= w_flush_done;
      r_err  <= w_start_bad;
    end
  end

`ifdef LB_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin : p_stall_cnt
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == LB_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (r_busy && pix_valid && !w_pix_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign pix_ready = w_pix_ready;
  assign wr_en     = w_accept ? lb_onehot(w_sels.bot) : 3'b000;
  assign addr      = r_col;
  assign top_sel   = r_sels_out.top;
  assign mid_sel   = r_sels_out.mid;
  assign bot_sel   = r_sels_out.bot;
  assign win_valid = r_win_valid;
  assign win_col   = r_win_col;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
